wired_cdb_arbiter: RTL and testbench
====================================

// Module: wired_cdb_arbiter
// PURPOSE
//  Shares the two CDB write-back lanes among the two ALU, one LSU and one MDU result ports.
//  Lane k writes ROB bank k; a result's bank is rid[BANK_BIT], so results steer to a fixed lane.
//  Per lane, fixed priority ALU0 > ALU1 > LSU > MDU; granted results are registered onto cdb_o.
//  Sits between the execute-side issue queues (cdb_payload_o/cdb_valid_o/cdb_ready_i) and the CDB/ROB.
// PARAMETERS
//  BANK_BIT  0  bit of pipeline_cdb_t.rid that selects the ROB bank / CDB lane
//  AGE_MAX   7  starvation threshold in cycles (used only with WIRED_CDB_ARB_AGING_EN); >=1
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset: synchronous, active-low
//  flush_i      in   1        backend flush; discard everything
//  alu_cdb_i    in   2xCDB    ALU results, pipeline_cdb_t
//  alu_valid_i  in   2        ALU result valid
//  alu_ready_o  out  2        ALU result accepted this cycle
//  lsu_cdb_i    in   CDB      LSU result
//  lsu_valid_i  in   1        LSU result valid
//  lsu_ready_o  out  1        LSU result accepted
//  mdu_cdb_i    in   CDB      MDU result
//  mdu_valid_i  in   1        MDU result valid
//  mdu_ready_o  out  1        MDU result accepted
//  cdb_o        out  2xCDB    broadcast payload, lane k = ROB bank k
//  cdb_valid_o  out  2        lane valid
// BEHAVIOUR
//  - Handshake: valid/ready; a transfer occurs when valid&ready. *_ready_o depends combinationally on
//    the *_valid_i signals; requesters must not make valid depend on ready, and must hold payload until accepted.
//  - Per lane k: candidates = requesters with valid & rid[BANK_BIT]==k; the highest-priority candidate
//    is granted (ready=1). All others see ready=0. Both lanes are arbitrated independently in the same cycle.
//  - Latency 1: a grant in cycle N appears on cdb_o[k]/cdb_valid_o[k] in cycle N+1. The CDB has no
//    backpressure; each lane carries at most one result per cycle.
//  - cdb_valid_o[k] <= 1 iff lane k granted; cdb_o[k] updated only on grant (holds otherwise).
//  - Reset (rst_n=0 at clk): cdb_valid_o=0, cdb_o=0, aging counters=0. *_ready_o=0 while rst_n=0.
//  - flush_i=1: every *_ready_o=1 (results drained and dropped), cdb_valid_o<=0 next cycle, counters<=0.
//    flush_i has priority over grants in the same cycle; rst_n has priority over flush_i.
//  - Same-bank collision (e.g. ALU0 and ALU1 both rid[0]=0): only ALU0 is accepted; ALU1 retries.
//  - Different banks: two results can retire in one cycle from any pair of requesters.
// CONFIGURATION
//  WIRED_CDB_ARB_AGING_EN defined: per lane, 2 saturating counters (LSU, MDU), width $clog2(AGE_MAX+1).
//    A counter increments each cycle its requester is a lane candidate but not granted, and clears when it is granted.
//    At AGE_MAX that requester is promoted above ALU0 for that lane.
//    If both are promoted, LSU wins. MDU's counter keeps counting (saturated) until MDU is granted.
//  Undefined: pure fixed priority, no counters; MDU can starve indefinitely under continuous ALU traffic.
// STRUCTURE
//  wired0_defines package: pipeline_cdb_t (rid, wdata, exception fields), ROB bank count = 2,
//    requester index enum cdb_req_e {REQ_ALU0, REQ_ALU1, REQ_LSU, REQ_MDU}.
//  Sub-module wired_cdb_lane_arb (instantiated x2): 4-way priority select + aging counters + output register.
//  Top level: bank decode, instantiate lanes, OR per-lane grants into *_ready_o.
// TESTING
//  - Reset: hold rst_n=0 with all valid=1 -> all ready=0; after release, cdb_valid_o=00 until the first grant.
//  - ALU0 rid=4, ALU1 rid=5 -> both ready=1; next cycle cdb_o[0].rid=4, cdb_o[1].rid=5, valid=11.
//  - ALU0 rid=2, ALU1 rid=6, LSU rid=8, all bank 0 -> ALU0 only; ALU1 granted next cycle, then LSU; lane1 idle.
//  - flush_i=1 with all four valid -> all ready=1; next cycle cdb_valid_o=00; counters cleared.
//  - AGING_EN, AGE_MAX=7: ALU0 bank1 valid every cycle, MDU rid=3 valid -> MDU granted after exactly
//    7 lost cycles (in the 8th cycle); counter returns to 0.
//  - Aging off, same stimulus for 100 cycles -> mdu_ready_o never 1; all ALU results appear in order.

Source files
------------

// File: rtl/wired_cdb_arbiter_pkg.sv
// CDB result types and requester encoding shared by the write-back arbiter slice.
package wired_cdb_arbiter_pkg;
  localparam int ROB_BANKS = 2;
  localparam int NUM_REQ   = 4;
  localparam int RID_W     = 6;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [RID_W-1:0] rid;
    logic [XLEN-1:0]  wdata;
    logic             exc_valid;
    logic [4:0]       exc_code;
  } pipeline_cdb_t;

  typedef enum logic [1:0] {REQ_ALU0, REQ_ALU1, REQ_LSU, REQ_MDU} cdb_req_e;

  // Lowest index wins, which matches ALU0 > ALU1 > LSU > MDU.
  function automatic logic [NUM_REQ-1:0] fixed_pick(input logic [NUM_REQ-1:0] cand);
    return cand & (~cand + NUM_REQ'(1));
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction
endpackage

// File: rtl/wired_cdb_arbiter_if.sv
// Result-port handshakes, CDB broadcast and aging debug view of the CDB arbiter.
interface wired_cdb_arbiter_if #(parameter int AGE_MAX = 7);
  import wired_cdb_arbiter_pkg::*;
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  // valid/ready: a result transfers in a cycle where valid & ready are both 1; the
  // requester keeps valid and payload stable until then, and never derives valid from ready.
  pipeline_cdb_t [1:0] alu_cdb_i;
  logic [1:0]          alu_valid_i;
  logic [1:0]          alu_ready_o;
  pipeline_cdb_t       lsu_cdb_i;
  logic                lsu_valid_i;
  logic                lsu_ready_o;
  pipeline_cdb_t       mdu_cdb_i;
  logic                mdu_valid_i;
  logic                mdu_ready_o;
  pipeline_cdb_t [1:0] cdb_o;
  logic [1:0]          cdb_valid_o;
  // age_dbg[lane][0] = LSU counter, age_dbg[lane][1] = MDU counter
  logic [1:0][1:0][AGE_W-1:0] age_dbg;

  modport master (
    output alu_cdb_i, alu_valid_i, lsu_cdb_i, lsu_valid_i, mdu_cdb_i, mdu_valid_i,
    input  alu_ready_o, lsu_ready_o, mdu_ready_o, cdb_o, cdb_valid_o, age_dbg
  );
  modport slave (
    input  alu_cdb_i, alu_valid_i, lsu_cdb_i, lsu_valid_i, mdu_cdb_i, mdu_valid_i,
    output alu_ready_o, lsu_ready_o, mdu_ready_o, cdb_o, cdb_valid_o, age_dbg
  );
endinterface

// File: rtl/wired_cdb_arbiter_lane_arb.sv
// One CDB lane: 4-way priority select, optional LSU/MDU aging (WIRED_CDB_ARB_AGING_EN), output register.
module wired_cdb_arbiter_lane_arb
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int AGE_MAX = 7
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic          [NUM_REQ-1:0]          cand,
  input  pipeline_cdb_t [NUM_REQ-1:0]          payload,
  output logic          [NUM_REQ-1:0]          grant,
  output pipeline_cdb_t                        cdb,
  output logic                                 cdb_valid,
  output logic [1:0][$clog2(AGE_MAX+1)-1:0]    age
);
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [NUM_REQ-1:0] pick;
  logic [1:0]         sel;

`ifdef WIRED_CDB_ARB_AGING_EN
  logic [AGE_W-1:0] age_lsu, age_mdu;
  logic             lsu_prom, mdu_prom;

  assign lsu_prom = cand[REQ_LSU] && (age_lsu == AGE_W'(AGE_MAX));
  assign mdu_prom = cand[REQ_MDU] && (age_mdu == AGE_W'(AGE_MAX));

  // A starved LSU/MDU jumps above ALU0; LSU wins when both are starved.
  always_comb begin
    pick = fixed_pick(cand);
    if (mdu_prom) pick = 4'b1000;
    if (lsu_prom) pick = 4'b0100;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      age_lsu <= '0;
      age_mdu <= '0;
    end else begin
      if (grant[REQ_LSU])
        age_lsu <= '0;
      else if (cand[REQ_LSU] && age_lsu != AGE_W'(AGE_MAX))
        age_lsu <= age_lsu + 1'b1;
      if (grant[REQ_MDU])
        age_mdu <= '0;
      else if (cand[REQ_MDU] && age_mdu != AGE_W'(AGE_MAX))
        age_mdu <= age_mdu + 1'b1;
    end
  end

  assign age = {age_mdu, age_lsu};
`else
  always_comb pick = fixed_pick(cand);
  assign age = '0;
`endif

  assign grant = (rst_n && !flush) ? pick : '0;
  assign sel   = onehot_idx(grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb       <= '0;
    end else begin
      cdb_valid <= |grant;
      if (|grant) cdb <= payload[sel];
    end
  end
endmodule

// File: rtl/wired_cdb_arbiter.sv
// Two-lane CDB write-back arbiter; lane = rid[BANK_BIT]. Optional aging via WIRED_CDB_ARB_AGING_EN.
module wired_cdb_arbiter
  import wired_cdb_arbiter_pkg::*;
#(
  parameter int BANK_BIT = 0,
  parameter int AGE_MAX  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  wired_cdb_arbiter_if.slave   bus
);
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  pipeline_cdb_t [NUM_REQ-1:0]            payload;
  logic          [NUM_REQ-1:0]            valid;
  logic [ROB_BANKS-1:0][NUM_REQ-1:0]      cand;
  logic [ROB_BANKS-1:0][NUM_REQ-1:0]      grant;
  pipeline_cdb_t [ROB_BANKS-1:0]          lane_cdb;
  logic          [ROB_BANKS-1:0]          lane_valid;
  logic [ROB_BANKS-1:0][1:0][AGE_W-1:0]   lane_age;
  logic          [NUM_REQ-1:0]            ready;

  assign payload = {bus.mdu_cdb_i, bus.lsu_cdb_i, bus.alu_cdb_i[1], bus.alu_cdb_i[0]};
  assign valid   = {bus.mdu_valid_i, bus.lsu_valid_i, bus.alu_valid_i};

  always_comb begin
    cand = '0;
    for (int k = 0; k < ROB_BANKS; k++)
      for (int r = 0; r < NUM_REQ; r++)
        cand[k][r] = valid[r] && (payload[r].rid[BANK_BIT] == k[0]);
  end

  for (genvar k = 0; k < ROB_BANKS; k++) begin : g_lane
    wired_cdb_arbiter_lane_arb #(.AGE_MAX(AGE_MAX)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_i),
      .cand      (cand[k]),
      .payload   (payload),
      .grant     (grant[k]),
      .cdb       (lane_cdb[k]),
      .cdb_valid (lane_valid[k]),
      .age       (lane_age[k])
    );
  end

  // Flush drains every port; reset masks everything including flush.
  assign ready = !rst_n ? '0 : (flush_i ? '1 : (grant[0] | grant[1]));

  assign bus.alu_ready_o = ready[1:0];
  assign bus.lsu_ready_o = ready[REQ_LSU];
  assign bus.mdu_ready_o = ready[REQ_MDU];
  assign bus.cdb_o       = lane_cdb;
  assign bus.cdb_valid_o = lane_valid;
  assign bus.age_dbg     = lane_age;
endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Directed bench for wired_cdb_arbiter; aging scenario selected by WIRED_CDB_ARB_AGING_EN.
module tb_wired_cdb_arbiter;
  import wired_cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  wired_cdb_arbiter_if #(.AGE_MAX(7)) bus ();

  wired_cdb_arbiter #(.BANK_BIT(0), .AGE_MAX(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic pipeline_cdb_t mk(input int rid, input logic [31:0] wdata);
    pipeline_cdb_t p;
    p = '0;
    p.rid   = RID_W'(rid);
    p.wdata = wdata;
    return p;
  endfunction

  task automatic idle_inputs();
    bus.alu_valid_i = 2'b00;
    bus.lsu_valid_i = 1'b0;
    bus.mdu_valid_i = 1'b0;
    bus.alu_cdb_i   = '0;
    bus.lsu_cdb_i   = '0;
    bus.mdu_cdb_i   = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    flush_i = 1'b1;
    bus.alu_cdb_i[0] = mk(4, 32'h1); bus.alu_cdb_i[1] = mk(5, 32'h2);
    bus.lsu_cdb_i = mk(6, 32'h3); bus.mdu_cdb_i = mk(7, 32'h4);
    bus.alu_valid_i = 2'b11; bus.lsu_valid_i = 1'b1; bus.mdu_valid_i = 1'b1;
    #2;
    n_checks++;
    if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flush_ready: got %b expected 0000", {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o});
    end
    @(negedge clk);
    flush_i = 1'b0;
    #2;
    n_checks++;
    if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0000", {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.cdb_valid_o !== 2'b00 || bus.cdb_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid %b cdb %h expected valid 00 cdb 0", bus.cdb_valid_o, bus.cdb_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (bus.cdb_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: valid %b expected 00", bus.cdb_valid_o);
    end
  endtask

  task automatic test_two_lanes();
    @(negedge clk);
    bus.alu_cdb_i[0] = mk(4, 32'hAAAA_0004);
    bus.alu_cdb_i[1] = mk(5, 32'hBBBB_0005);
    bus.alu_valid_i  = 2'b11;
    #2;
    n_checks++;
    if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== 4'b1100) begin
      n_fail++;
      $display("FAIL two_lanes_ready: got %b expected 1100", {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.cdb_valid_o !== 2'b11 || bus.cdb_o[0].rid !== 6'd4 || bus.cdb_o[1].rid !== 6'd5 ||
        bus.cdb_o[0].wdata !== 32'hAAAA_0004 || bus.cdb_o[1].wdata !== 32'hBBBB_0005) begin
      n_fail++;
      $display("FAIL two_lanes_out: valid %b rid0 %0d rid1 %0d expected 11 4 5",
               bus.cdb_valid_o, bus.cdb_o[0].rid, bus.cdb_o[1].rid);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_ready [3];
    logic [5:0]  exp_rid   [3];
    exp_ready[0] = 4'b0100; exp_ready[1] = 4'b1000; exp_ready[2] = 4'b0010;
    exp_rid[0] = 6'd2; exp_rid[1] = 6'd6; exp_rid[2] = 6'd8;
    @(negedge clk);
    bus.alu_cdb_i[0] = mk(2, 32'h2); bus.alu_cdb_i[1] = mk(6, 32'h6);
    bus.lsu_cdb_i = mk(8, 32'h8);
    bus.alu_valid_i = 2'b11; bus.lsu_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++;
      if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== exp_ready[c]) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", c, {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o}, exp_ready[c]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.cdb_valid_o !== 2'b01 || bus.cdb_o[0].rid !== exp_rid[c]) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: valid %b rid %0d expected 01 %0d", c, bus.cdb_valid_o, bus.cdb_o[0].rid, exp_rid[c]);
      end
      @(negedge clk);
      // retire the requester the model says was accepted
      if (c == 0) bus.alu_valid_i[0] = 1'b0;
      if (c == 1) bus.alu_valid_i[1] = 1'b0;
      if (c == 2) bus.lsu_valid_i = 1'b0;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.cdb_valid_o !== 2'b00 || bus.cdb_o[0].rid !== 6'd8) begin
      n_fail++;
      $display("FAIL b2b_hold: valid %b rid %0d expected 00 8", bus.cdb_valid_o, bus.cdb_o[0].rid);
    end
  endtask

  task automatic test_cross_banks();
    @(negedge clk);
    idle_inputs();
    bus.alu_cdb_i[1] = mk(3, 32'h33);
    bus.lsu_cdb_i    = mk(9, 32'h99);
    bus.mdu_cdb_i    = mk(10, 32'hAA);
    bus.alu_valid_i  = 2'b10; bus.lsu_valid_i = 1'b1; bus.mdu_valid_i = 1'b1;
    #2;
    n_checks++;
    if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== 4'b1001) begin
      n_fail++;
      $display("FAIL cross_ready: got %b expected 1001", {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.cdb_valid_o !== 2'b11 || bus.cdb_o[0].rid !== 6'd10 || bus.cdb_o[1].rid !== 6'd3) begin
      n_fail++;
      $display("FAIL cross_out: valid %b rid0 %0d rid1 %0d expected 11 10 3",
               bus.cdb_valid_o, bus.cdb_o[0].rid, bus.cdb_o[1].rid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.alu_cdb_i[0] = mk(12, 32'hC); bus.alu_cdb_i[1] = mk(13, 32'hD);
    bus.lsu_cdb_i = mk(14, 32'hE); bus.mdu_cdb_i = mk(15, 32'hF);
    bus.alu_valid_i = 2'b11; bus.lsu_valid_i = 1'b1; bus.mdu_valid_i = 1'b1;
    flush_i = 1'b1;
    #2;
    n_checks++;
    if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== 4'b1111) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 1111", {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.cdb_valid_o !== 2'b00 || bus.cdb_o[0].rid !== 6'd10 || bus.cdb_o[1].rid !== 6'd3) begin
      n_fail++;
      $display("FAIL flush_out: valid %b rid0 %0d rid1 %0d expected 00 10 3",
               bus.cdb_valid_o, bus.cdb_o[0].rid, bus.cdb_o[1].rid);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    n_checks++;
    if ({bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o} !== 4'b1111) begin
      n_fail++;
      $display("FAIL flush_ready_idle: got %b expected 1111", {bus.alu_ready_o, bus.lsu_ready_o, bus.mdu_ready_o});
    end
    @(negedge clk);
    flush_i = 1'b0;
  endtask

`ifdef WIRED_CDB_ARB_AGING_EN
  task automatic test_aging();
    logic [31:0] alu_w;
    alu_w = 32'h100;
    @(negedge clk);
    idle_inputs();
    bus.alu_cdb_i[0] = mk(1, alu_w); bus.mdu_cdb_i = mk(3, 32'hD3);
    bus.alu_valid_i = 2'b01; bus.mdu_valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #2;
      n_checks++;
      if (bus.mdu_ready_o !== (i == 8) || bus.alu_ready_o !== ((i == 8) ? 2'b00 : 2'b01)) begin
        n_fail++;
        $display("FAIL aging_ready[%0d]: mdu %b alu %b expected %b %b", i, bus.mdu_ready_o,
                 bus.alu_ready_o, (i == 8), ((i == 8) ? 2'b00 : 2'b01));
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.age_dbg[1][1] !== ((i == 8) ? 3'd0 : 3'(i)) ||
          bus.cdb_o[1].rid !== ((i == 8) ? 6'd3 : 6'd1) ||
          (i != 8 && bus.cdb_o[1].wdata !== alu_w)) begin
        n_fail++;
        $display("FAIL aging_out[%0d]: age %0d rid %0d wdata %h", i, bus.age_dbg[1][1], bus.cdb_o[1].rid, bus.cdb_o[1].wdata);
      end
      @(negedge clk);
      if (i != 8) begin
        alu_w = alu_w + 1;
        bus.alu_cdb_i[0] = mk(1, alu_w);
      end else begin
        bus.mdu_valid_i = 1'b0;
      end
    end
    bus.mdu_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.age_dbg !== '0) begin
      n_fail++;
      $display("FAIL aging_flush_clear: age %h expected 0", bus.age_dbg);
    end
    @(negedge clk);
    flush_i = 1'b0;
    idle_inputs();
  endtask
`else
  task automatic test_starvation();
    @(negedge clk);
    idle_inputs();
    bus.mdu_cdb_i = mk(3, 32'hD3);
    bus.alu_valid_i = 2'b01; bus.mdu_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.alu_cdb_i[0] = mk(1, 32'(i));
      #2;
      n_checks++;
      if (bus.mdu_ready_o !== 1'b0 || bus.alu_ready_o !== 2'b01) begin
        n_fail++;
        $display("FAIL starve_ready[%0d]: mdu %b alu %b expected 0 01", i, bus.mdu_ready_o, bus.alu_ready_o);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.cdb_valid_o !== 2'b10 || bus.cdb_o[1].wdata !== 32'(i)) begin
        n_fail++;
        $display("FAIL starve_out[%0d]: valid %b wdata %0d expected 10 %0d", i, bus.cdb_valid_o, bus.cdb_o[1].wdata, i);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    idle_inputs();
    test_reset();
    test_two_lanes();
    test_back_to_back();
    test_cross_banks();
    test_flush();
`ifdef WIRED_CDB_ARB_AGING_EN
    test_aging();
`else
    test_starvation();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
